// File: rtl/bomba_pkg.sv
// Shared types for the level-controlled pump: FSM states and fault-cause codes.
package bomba_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    LLENANDO = 2'd1,
    ALARMA   = 2'd2
  } estado_t;

  localparam logic [1:0] FALLA_NONE    = 2'b00;
  localparam logic [1:0] FALLA_PATRON  = 2'b01;
  localparam logic [1:0] FALLA_TIMEOUT = 2'b10;

endpackage

// File: rtl/bomba_antirrebote.sv
// Two-flop synchroniser plus debounce filter for the level sensor vector.
// The first accepted value raises ok_o; until then even an unchanged value must prove stable.
module bomba_antirrebote #(
  parameter int W       = 3,
  parameter int DEB_CYC = 4
) (
  input  logic         ck,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         ok_o
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  sync1_q, sync2_q, cand_q, cand_d, filt_q, filt_d;
  logic [1:0]    prim_q;
  logic [CW-1:0] cnt_q, cnt_d, hits_s;
  logic          ok_q, ok_d;

  // Count consecutive edges showing the same candidate value; a different value restarts at 1.
  always_comb begin
    cand_d = cand_q;
    filt_d = filt_q;
    cnt_d  = cnt_q;
    ok_d   = ok_q;
    hits_s = ((cnt_q != '0) && (sync2_q == cand_q)) ? cnt_q + CNT_ONE : CNT_ONE;
    if (prim_q[1] && ((sync2_q != filt_q) || !ok_q)) begin
      if (hits_s == DEB_MAX) begin
        filt_d = sync2_q;
        ok_d   = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d  = hits_s;
        cand_d = sync2_q;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prim_q  <= 2'b00;
      cand_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prim_q  <= {prim_q[0], 1'b1};
      cand_q  <= cand_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
    end
  end

  assign q_o  = filt_q;
  assign ok_o = ok_q;

endmodule

// File: rtl/bomba_niveles.sv
// Tank-fill pump controller driven by debounced thermometer-coded level sensors.
// Define BOMBA_TIMEOUT_EN to enable the dry-run timeout alarm (fault code 10).
module bomba_niveles
  import bomba_pkg::*;
#(
  parameter int N_SENS  = 3,
  parameter int DEB_CYC = 4,
  parameter int LO_IDX  = 0,
  parameter int MIN_ON  = 16,
  parameter int MAX_ON  = 1024
) (
  input  logic                        ck,
  input  logic                        rst_i,
  input  logic [N_SENS-1:0]           sensores_i,
  input  logic                        ack_i,
  output logic                        bomba_o,
  output logic                        alarma_o,
  output logic [$clog2(N_SENS+1)-1:0] nivel_o,
  output logic [1:0]                  falla_o
);

  localparam int NW    = $clog2(N_SENS + 1);
  localparam int RUN_W = $clog2(MAX_ON);
  localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(MIN_ON - 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
`ifdef BOMBA_TIMEOUT_EN
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_ON - 1);
`else
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MIN_ON - 1);
`endif

  logic [N_SENS-1:0] filt_s, inc_s;
  logic              deb_ok_s, valid_s, full_s;
  logic [NW-1:0]     pop_s;
  estado_t           state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [1:0]        falla_q, falla_d;
  logic              bomba_q, alarma_q;
  logic [NW-1:0]     nivel_q;

  bomba_antirrebote #(
    .W       (N_SENS),
    .DEB_CYC (DEB_CYC)
  ) u_antirrebote (
    .ck    (ck),
    .rst_i (rst_i),
    .d_i   (sensores_i),
    .q_o   (filt_s),
    .ok_o  (deb_ok_s)
  );

  // A thermometer code is 2^k-1, so adding one clears every set bit.
  always_comb begin
    inc_s   = filt_s + {{(N_SENS-1){1'b0}}, 1'b1};
    valid_s = ((filt_s & inc_s) == '0);
    full_s  = &filt_s;
    pop_s   = '0;
    for (int i = 0; i < N_SENS; i++) begin
      pop_s = pop_s + {{(NW-1){1'b0}}, filt_s[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    falla_d = falla_q;
    case (state_q)
      REPOSO: begin
        if (deb_ok_s && valid_s && !filt_s[LO_IDX]) begin
          state_d = LLENANDO;
          run_d   = '0;
        end else begin
          state_d = REPOSO;
        end
      end
      LLENANDO: begin
        if (full_s && (run_q >= RUN_MIN)) begin
          state_d = REPOSO;
`ifdef BOMBA_TIMEOUT_EN
        end else if (run_q == RUN_SAT) begin
          state_d = ALARMA;
          falla_d = FALLA_TIMEOUT;
`endif
        end else if (run_q != RUN_SAT) begin
          run_d = run_q + RUN_ONE;
        end else begin
          run_d = run_q;
        end
      end
      ALARMA: begin
        if (ack_i && valid_s) begin
          state_d = REPOSO;
          falla_d = FALLA_NONE;
        end else begin
          state_d = ALARMA;
        end
      end
      default: begin
        state_d = REPOSO;
      end
    endcase
    // An impossible sensor pattern overrides every other transition.
    if (deb_ok_s && !valid_s) begin
      state_d = ALARMA;
      falla_d = FALLA_PATRON;
    end else begin
      falla_d = falla_d;
    end
  end

  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= REPOSO;
      run_q    <= '0;
      falla_q  <= FALLA_NONE;
      bomba_q  <= 1'b0;
      alarma_q <= 1'b0;
      nivel_q  <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      falla_q  <= falla_d;
      bomba_q  <= (state_d == LLENANDO);
      alarma_q <= (state_d == ALARMA);
      nivel_q  <= pop_s;
    end
  end

  assign bomba_o  = bomba_q;
  assign alarma_o = alarma_q;
  assign nivel_o  = nivel_q;
  assign falla_o  = falla_q;

endmodule

// File: tb/tb_bomba_niveles.sv
// Table-driven scoreboard bench for bomba_niveles (N_SENS=3, DEB_CYC=4, MIN_ON=16, MAX_ON=64).
module tb_bomba_niveles;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sens = 3'b000;
  logic       ack = 1'b0;
  logic       bomba, alarma;
  logic [1:0] nivel, falla;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sens;
    logic       ack;
    int         n;
    logic       b;
    logic       a;
    logic [1:0] niv;
    logic [1:0] fal;
    string      name;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[15];

  bomba_niveles #(
    .N_SENS  (3),
    .DEB_CYC (4),
    .LO_IDX  (0),
    .MIN_ON  (16),
    .MAX_ON  (64)
  ) dut (
    .ck         (ck),
    .rst_i      (rst),
    .sensores_i (sens),
    .ack_i      (ack),
    .bomba_o    (bomba),
    .alarma_o   (alarma),
    .nivel_o    (nivel),
    .falla_o    (falla)
  );

  always #5 ck = ~ck;

  function automatic vec_t mk(input logic [2:0] s, input logic a_in, input int n,
                              input logic b, input logic a, input logic [1:0] niv,
                              input logic [1:0] fal, input string name);
    vec_t v;
    v.sens = s; v.ack = a_in; v.n = n; v.b = b; v.a = a; v.niv = niv; v.fal = fal; v.name = name;
    return v;
  endfunction

  // Drive inputs, queue the expectation, wait n edges, then pop and compare.
  task automatic step(input vec_t v);
    vec_t e;
    sens = v.sens;
    ack  = v.ack;
    exp_q.push_back(v);
    if (v.n > 0) begin
      repeat (v.n) @(posedge ck);
      #1;
    end
    e = exp_q.pop_front();
    checks++;
    if (bomba !== e.b || alarma !== e.a || nivel !== e.niv || falla !== e.fal) begin
      errors++;
      $display("FAIL %s: got bomba=%b alarma=%b nivel=%0d falla=%b, expected bomba=%b alarma=%b nivel=%0d falla=%b",
               e.name, bomba, alarma, nivel, falla, e.b, e.a, e.niv, e.fal);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(3'b000, 1'b0, 6,  1'b0, 1'b0, 2'd0, 2'b00, "pre_fill");
    tbl[1]  = mk(3'b000, 1'b0, 1,  1'b1, 1'b0, 2'd0, 2'b00, "fill_start_7");
    tbl[2]  = mk(3'b000, 1'b0, 5,  1'b1, 1'b0, 2'd0, 2'b00, "run5");
    tbl[3]  = mk(3'b111, 1'b0, 6,  1'b1, 1'b0, 2'd0, 2'b00, "full_early");
    tbl[4]  = mk(3'b111, 1'b0, 4,  1'b1, 1'b0, 2'd3, 2'b00, "min_on_hold");
    tbl[5]  = mk(3'b111, 1'b0, 1,  1'b0, 1'b0, 2'd3, 2'b00, "min_on_end");
    tbl[6]  = mk(3'b111, 1'b0, 10, 1'b0, 1'b0, 2'd3, 2'b00, "idle_full");
    tbl[7]  = mk(3'b000, 1'b0, 3,  1'b0, 1'b0, 2'd3, 2'b00, "glitch");
    tbl[8]  = mk(3'b111, 1'b0, 8,  1'b0, 1'b0, 2'd3, 2'b00, "glitch_after");
    tbl[9]  = mk(3'b101, 1'b0, 6,  1'b0, 1'b0, 2'd3, 2'b00, "invalid_pending");
    tbl[10] = mk(3'b101, 1'b0, 1,  1'b0, 1'b1, 2'd2, 2'b01, "invalid_alarm");
    tbl[11] = mk(3'b101, 1'b1, 3,  1'b0, 1'b1, 2'd2, 2'b01, "ack_while_invalid");
    tbl[12] = mk(3'b011, 1'b1, 6,  1'b0, 1'b1, 2'd2, 2'b01, "ack_wait_valid");
    tbl[13] = mk(3'b011, 1'b1, 1,  1'b0, 1'b0, 2'd2, 2'b00, "ack_clear");
    tbl[14] = mk(3'b011, 1'b1, 3,  1'b0, 1'b0, 2'd2, 2'b00, "ack_ignored_reposo");

    repeat (3) @(posedge ck);
    #1;
    step(mk(3'b000, 1'b0, 0, 1'b0, 1'b0, 2'd0, 2'b00, "reset_state"));
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i]);
    end

    // Dry run with the level stuck at the lowest sensor.
    step(mk(3'b000, 1'b0, 6,  1'b0, 1'b0, 2'd2, 2'b00, "refill_pending"));
    step(mk(3'b000, 1'b0, 1,  1'b1, 1'b0, 2'd0, 2'b00, "refill_start"));
    step(mk(3'b001, 1'b0, 63, 1'b1, 1'b0, 2'd1, 2'b00, "stuck_run63"));
`ifdef BOMBA_TIMEOUT_EN
    step(mk(3'b001, 1'b0, 1,  1'b0, 1'b1, 2'd1, 2'b10, "timeout_alarm"));
    step(mk(3'b001, 1'b1, 1,  1'b0, 1'b0, 2'd1, 2'b00, "timeout_ack"));
    step(mk(3'b111, 1'b0, 8,  1'b0, 1'b0, 2'd3, 2'b00, "after_timeout_full"));
`else
    step(mk(3'b001, 1'b0, 1,   1'b1, 1'b0, 2'd1, 2'b00, "no_timeout_64"));
    step(mk(3'b001, 1'b0, 100, 1'b1, 1'b0, 2'd1, 2'b00, "no_timeout_long"));
    step(mk(3'b111, 1'b0, 6,   1'b1, 1'b0, 2'd1, 2'b00, "sat_full_pending"));
    step(mk(3'b111, 1'b0, 1,   1'b0, 1'b0, 2'd3, 2'b00, "sat_full_stop"));
`endif

    // Reset in the middle of a fill.
    step(mk(3'b000, 1'b0, 7, 1'b1, 1'b0, 2'd0, 2'b00, "fill_before_rst"));
    step(mk(3'b000, 1'b0, 3, 1'b1, 1'b0, 2'd0, 2'b00, "fill_running"));
    @(negedge ck);
    rst = 1'b1;
    #1;
    step(mk(3'b000, 1'b0, 0, 1'b0, 1'b0, 2'd0, 2'b00, "async_rst_drop"));
    @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    step(mk(3'b000, 1'b0, 6, 1'b0, 1'b0, 2'd0, 2'b00, "no_early_restart"));
    step(mk(3'b000, 1'b0, 1, 1'b1, 1'b0, 2'd0, 2'b00, "restart_7"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bomba_niveles.md
BOMBA_NIVELES -- requirements
Module: bomba_niveles

Interface
REQ-001 SHALL have parameter N_SENS, default 3: number of level sensors, at least 2; bit 0 is the lowest.
REQ-002 SHALL have parameter DEB_CYC, default 4: consecutive stable cycles required to accept a sensor change, at least 1.
REQ-003 SHALL have parameter LO_IDX, default 0: index of the sensor whose loss starts filling, less than N_SENS-1.
REQ-004 SHALL have parameter MIN_ON, default 16: minimum pump run, in cycles.
REQ-005 SHALL have parameter MAX_ON, default 1024: dry-run timeout, in cycles, greater than MIN_ON.
REQ-006 SHALL have port ck, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port sensores_i, input, N_SENS bits: raw level sensors, asynchronous, 1 = wet.
REQ-009 SHALL have port ack_i, input, 1 bit: alarm acknowledge, level-sampled.
REQ-010 SHALL have port bomba_o, output, 1 bit: pump on.
REQ-011 SHALL have port alarma_o, output, 1 bit: alarm.
REQ-012 SHALL have port nivel_o, output, $clog2(N_SENS+1) bits: debounced level, as a count of wet sensors.
REQ-013 SHALL have port falla_o, output, 2 bits: latched cause; 01 = invalid pattern, 10 = timeout, 00 = none.

Function
REQ-014 SHALL pass sensores_i through a 2-flop synchroniser before any other logic.
REQ-015 SHALL update the filtered vector only after the synchronised vector has differed from it with the same value for DEB_CYC consecutive edges; any change in that value SHALL restart the count.
REQ-016 SHALL assert an internal deb_ok after the first filtered update; the FSM SHALL ignore sensors until deb_ok is set.
REQ-017 SHALL treat a filtered vector as valid only if it is a thermometer code (no 1 above a 0); nivel_o SHALL equal its popcount and be registered.
REQ-018 SHALL implement a 3-state FSM: REPOSO, LLENANDO, ALARMA; bomba_o = (state==LLENANDO) and alarma_o = (state==ALARMA), both registered.
REQ-019 REPOSO to LLENANDO SHALL occur when deb_ok is set, the vector is valid and filtered[LO_IDX]==0; the run counter SHALL clear.
REQ-020 LLENANDO to REPOSO SHALL occur when the filtered vector is all ones and run counter >= MIN_ON-1; if full earlier, the pump SHALL keep running until MIN_ON cycles have elapsed.
REQ-021 Any state to ALARMA SHALL occur on an invalid filtered vector, setting falla_o=01; this has priority over all other transitions.
REQ-022 LLENANDO to ALARMA SHALL occur when run counter reaches MAX_ON-1 without full, setting falla_o=10.
REQ-023 ALARMA to REPOSO SHALL occur only when ack_i==1 and the vector is valid; falla_o SHALL clear on that edge. ack_i SHALL be ignored in other states.
REQ-024 The run counter SHALL saturate at MAX_ON-1 and never wrap.
REQ-025 Latency from a raw change to a bomba_o change SHALL be DEB_CYC+3 edges.

Reset
REQ-026 While rst_i is asserted: state REPOSO; bomba_o, alarma_o, nivel_o, falla_o, the filtered vector, deb_ok, the synchroniser and all counters SHALL be 0.
REQ-027 Reset mid-fill SHALL drop bomba_o immediately (asynchronous), and refilling SHALL require a fresh debounce.

Configuration
REQ-028 Macro BOMBA_TIMEOUT_EN defined SHALL implement REQ-022; undefined SHALL omit the timeout logic, falla_o=10 SHALL be unreachable and the counter SHALL saturate at MIN_ON-1.

Structure
REQ-029 Package bomba_pkg SHALL hold the state enum (REPOSO, LLENANDO, ALARMA) and the falla_o code constants.
REQ-030 The synchroniser and debounce SHALL be in sub-module bomba_antirrebote, parametrised by width and DEB_CYC.

Verification (defaults, MAX_ON=64, BOMBA_TIMEOUT_EN defined)
REQ-031 Reset, then sensores_i=000 stable -> bomba_o=1 exactly 7 edges after reset release, nivel_o=0.
REQ-032 Filling, sensores_i=111 at run cycle 5 -> bomba_o stays 1 until the 16th run cycle, then REPOSO with nivel_o=3.
REQ-033 sensores_i=101 held 4 cycles -> alarma_o=1, falla_o=01, bomba_o=0; ack_i=1 with 011 -> REPOSO next edge, falla_o=00.
REQ-034 Filling with sensores_i stuck at 001 -> alarma_o=1, falla_o=10 after 64 run cycles.
REQ-035 A glitch to 000 lasting 3 cycles in REPOSO with 111 -> no filtered change and bomba_o stays 0.
REQ-036 rst_i pulse during LLENANDO -> bomba_o=0 with no clock edge, and no restart before 7 edges.
